// File: rtl/alu181_nibble_seq_if.sv
// Requester-side bus of alu181_nibble_seq: start/ready/done handshake,
// operation select, operands and the assembled result.
interface alu181_nibble_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [3:0]       op_s;
    logic             op_m;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             all_eq;

    modport master (
        output start, op_s, op_m, cin, a, b,
        input  ready, done, result, cout, all_eq
    );

    modport slave (
        input  start, op_s, op_m, cin, a, b,
        output ready, done, result, cout, all_eq
    );
endinterface

// File: rtl/alu181_nibble_seq.sv
// WIDTH-bit ALU operation sequenced nibble-by-nibble through one external 74181
// slice, LSB nibble first. Define ALU_SEQ_EQ_EN to enable the all_eq accumulator.
module alu181_nibble_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    alu181_nibble_seq_if.slave  req,
    output logic [3:0]          alu_a,
    output logic [3:0]          alu_b,
    output logic [3:0]          alu_s,
    output logic                alu_m,
    output logic                alu_cn,
    input  logic [3:0]          alu_f,
    input  logic                alu_cn4,
    input  logic                alu_eq
);
    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W+1:0] off;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       s_q;
    logic             m_q;

    assign off = {idx, 2'b00};

    // Sequencer: accept, walk the nibbles rippling the slice carry, report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            carry_q    <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            s_q        <= '0;
            m_q        <= 1'b0;
            req.ready  <= 1'b1;
            req.done   <= 1'b0;
            req.result <= '0;
            req.cout   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req.start) begin
                        a_q       <= req.a;
                        b_q       <= req.b;
                        s_q       <= req.op_s;
                        m_q       <= req.op_m;
                        carry_q   <= req.cin;
                        idx       <= '0;
                        req.ready <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    req.result[off +: 4] <= alu_f;
                    carry_q              <= alu_cn4;
                    if (idx == LAST_IDX) begin
                        idx      <= '0;
                        req.done <= 1'b1;
                        req.cout <= alu_cn4;
                        state    <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    req.done  <= 1'b0;
                    req.ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_EQ_EN
    logic eq_acc;

    // Equality accumulates across nibbles; published together with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_acc     <= 1'b1;
            req.all_eq <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req.start) begin
                        eq_acc <= 1'b1;
                    end
                end
                RUN: begin
                    eq_acc <= eq_acc & alu_eq;
                    if (idx == LAST_IDX) begin
                        req.all_eq <= eq_acc & alu_eq;
                    end
                end
                default: begin
                end
            endcase
        end
    end
`else
    logic unused_eq;

    assign unused_eq  = alu_eq;
    assign req.all_eq = 1'b0;
`endif

    // Slice drive: current nibble while running, quiescent values otherwise.
    always_comb begin
        alu_a  = 4'h0;
        alu_b  = 4'h0;
        alu_s  = 4'h0;
        alu_m  = 1'b0;
        alu_cn = 1'b1;
        if (state == RUN) begin
            alu_a  = a_q[off +: 4];
            alu_b  = b_q[off +: 4];
            alu_s  = s_q;
            alu_m  = m_q;
            alu_cn = carry_q;
        end
    end
endmodule

// File: tb/tb_alu181_nibble_seq.sv
// Scoreboard bench for alu181_nibble_seq driving a behavioural 74181 slice;
// expected results come from a whole-word model of the 74181 function set.
module tb_alu181_nibble_seq;
    localparam int unsigned W   = 16;
    localparam int unsigned NIB = W / 4;

    typedef struct packed {
        logic [W-1:0] result;
        logic         cout;
        logic         all_eq;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] alu_a, alu_b, alu_s, alu_f;
    logic       alu_m, alu_cn, alu_cn4, alu_eq;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu181_nibble_seq_if #(.WIDTH(W)) bus ();

    alu181_nibble_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.slave),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_s   (alu_s),
        .alu_m   (alu_m),
        .alu_cn  (alu_cn),
        .alu_f   (alu_f),
        .alu_cn4 (alu_cn4),
        .alu_eq  (alu_eq)
    );

    // External 74181 slice, active-high data: C_n=1 means no carry in.
    always_comb begin
        logic [3:0] x, y;
        logic [4:0] sum;
        x       = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
        y       = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
        sum     = {1'b0, x} + {1'b0, y} + {4'b0, ~alu_cn};
        alu_f   = alu_m ? ~(x ^ y) : sum[3:0];
        alu_cn4 = ~sum[4];
        alu_eq  = &alu_f;
    end

    function automatic logic eq_exp(input logic v);
`ifdef ALU_SEQ_EQ_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic e);
        exp_t t;
        t.result = r;
        t.cout   = c;
        t.all_eq = eq_exp(e);
        return t;
    endfunction

    // Whole-word reference: the full-width 74181 operation equals the chained slices.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] s, input logic m, input logic c);
        logic [W-1:0] x, y, r;
        logic [W:0]   sum;
        x   = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
        y   = (a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}});
        sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ~c};
        r   = m ? ~(x ^ y) : sum[W-1:0];
        return mk(r, ~sum[W], &r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done=1 expected no pending op");
            end else begin
                e = sb.pop_front();
                chk("result", 32'(bus.result), 32'(e.result));
                chk("cout",   32'(bus.cout),   32'(e.cout));
                chk("all_eq", 32'(bus.all_eq), 32'(e.all_eq));
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 50 && bus.ready !== 1'b1; i++) @(negedge clk);
        chk("ready_wait", 32'(bus.ready), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                          input logic m, input logic c, input exp_t e, input bit inject,
                          input bit check_cn, input logic [NIB-1:0] exp_cn);
        logic [NIB-1:0] cn;
        wait_ready();
        bus.a = a; bus.b = b; bus.op_s = s; bus.op_m = m; bus.cin = c;
        bus.start = 1'b1;
        @(negedge clk);
        sb.push_back(e);
        bus.start = 1'b0;
        chk("ready_low", 32'(bus.ready), 32'd0);
        bus.a = W'($urandom); bus.b = W'($urandom);
        bus.op_s = 4'($urandom); bus.op_m = 1'($urandom); bus.cin = 1'($urandom);
        for (int k = 0; k < int'(NIB); k++) begin
            cn[k] = alu_cn;
            if (inject) begin
                bus.start = (k % 2 == 0);
                bus.a = W'($urandom); bus.b = W'($urandom);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("done_latency", 32'(bus.done), 32'd1);
        if (check_cn) chk("cn_seq", 32'(cn), 32'(exp_cn));
        @(negedge clk);
        chk("ready_after", 32'(bus.ready), 32'd1);
        chk("done_pulse",  32'(bus.done),  32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1, e2;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.op_s = '0; bus.op_m = 1'b0; bus.cin = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready",  32'(bus.ready),  32'd1);
        chk("rst_done",   32'(bus.done),   32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_cout",   32'(bus.cout),   32'd1);
        chk("rst_all_eq", 32'(bus.all_eq), 32'd0);
        chk("rst_drive",  32'({alu_a, alu_b, alu_s, alu_m, alu_cn}), 32'h00001);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h0FF1, 4'b1001, 1'b0, 1'b1, mk(16'h2225, 1'b1, 1'b0), 0, 0, '0);
        run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, mk(16'h0000, 1'b0, 1'b0), 0, 1, 4'b0001);
        run_op(16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, mk(16'hFFFF, 1'b1, 1'b1), 0, 0, '0);
        run_op(16'h5A5B, 16'h5A5A, 4'b0110, 1'b0, 1'b1, mk(16'h0000, 1'b0, 1'b0), 0, 0, '0);
        run_op(16'h00F0, W'($urandom), 4'b0000, 1'b1, 1'b1, mk(16'hFF0F, 1'b1, 1'b0), 0, 0, '0);
        run_op(16'h1000, W'($urandom), 4'b1111, 1'b0, 1'b1, mk(16'h0FFF, 1'b0, 1'b0), 0, 0, '0);
        run_op(16'h1234, 16'h0FF1, 4'b1001, 1'b0, 1'b1, mk(16'h2225, 1'b1, 1'b0), 1, 0, '0);

        // Reset in the middle of an operation: aborts it with no done.
        wait_ready();
        bus.a = 16'h1234; bus.b = 16'h0FF1; bus.op_s = 4'b1001; bus.op_m = 1'b0; bus.cin = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("partial_result", 32'(bus.result[7:0]), 32'h25);
        rst_n = 1'b0;
        #1;
        chk("abort_ready",  32'(bus.ready),  32'd1);
        chk("abort_done",   32'(bus.done),   32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_cout",   32'(bus.cout),   32'd1);
        chk("abort_cn",     32'(alu_cn),     32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_op(16'h0F0F, 16'h00F1, 4'b1001, 1'b0, 1'b1, model(16'h0F0F, 16'h00F1, 4'b1001, 1'b0, 1'b1), 0, 0, '0);

        // Back-to-back: start held high through DONE is taken at the first IDLE edge.
        wait_ready();
        e1 = model(16'hABCD, 16'h1111, 4'b1001, 1'b0, 1'b0);
        e2 = model(16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b1);
        bus.a = 16'hABCD; bus.b = 16'h1111; bus.op_s = 4'b1001; bus.op_m = 1'b0; bus.cin = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        sb.push_back(e1);
        for (int i = 0; i < 20 && bus.done !== 1'b1; i++) @(negedge clk);
        chk("b2b_done1", 32'(bus.done), 32'd1);
        bus.a = 16'h8000; bus.b = 16'h8000; bus.cin = 1'b1;
        sb.push_back(e2);
        @(negedge clk);
        chk("b2b_idle",   32'(bus.ready), 32'd1);
        @(negedge clk);
        chk("b2b_accept", 32'(bus.ready), 32'd0);
        bus.start = 1'b0;
        for (int i = 0; i < 20 && bus.done !== 1'b1; i++) @(negedge clk);
        chk("b2b_done2", 32'(bus.done), 32'd1);
        @(negedge clk);

        // Randomised operations against the whole-word model.
        for (int n = 0; n < 150; n++) begin
            logic [W-1:0] ra, rb;
            logic [3:0]   rs;
            logic         rm, rc;
            ra = W'($urandom); rb = W'($urandom); rs = 4'($urandom);
            rm = 1'($urandom); rc = 1'($urandom);
            if (n % 10 == 0) rb = ra;
            run_op(ra, rb, rs, rm, rc, model(ra, rb, rs, rm, rc), bit'($urandom_range(0, 3) == 0), 0, '0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
